dma_arbiter: RTL and testbench
==============================

DMA_ARBITER -- requirements
Module: dma_arbiter

Interface
REQ-001 The block SHALL have a parameter MAX_WAIT, default 4, giving the number of consecutive denied DMA cycles after which the DMA wins one cycle.
REQ-002 The block SHALL have the port CLK  in  1  clock, rising edge.
REQ-003 The block SHALL have the port RESET  in  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have the port CPU_REQ  in  1  CPU requests a memory access this cycle.
REQ-005 The block SHALL have the port CPU_WRITE  in  1  CPU access is a write.
REQ-006 The block SHALL have the port CPU_ADDRESS  in  8  CPU address.
REQ-007 The block SHALL have the port CPU_DATA_IN  in  8  CPU write data.
REQ-008 The block SHALL have the port CPU_DATA_OUT  out  8  read data to the CPU, equal to MEM_DATA_OUT at all times.
REQ-009 The block SHALL have the port CPU_STALL  out  1  CPU access not performed this cycle; the CPU holds its request.
REQ-010 The block SHALL have the port DMA_START  in  1  one-cycle start pulse.
REQ-011 The block SHALL have the ports DMA_SRC, DMA_DST, DMA_LEN  in  8 each  source address, destination address and byte count, sampled with DMA_START.
REQ-012 The block SHALL have the port BUSY  out  1  transfer in progress.
REQ-013 The block SHALL have the port DONE  out  1  one-cycle completion pulse.
REQ-014 The block SHALL have the ports MEM_WRITE out 1, MEM_ADDRESS out 8, MEM_DATA_IN out 8 and MEM_DATA_OUT in 8, connecting to the data memory (combinational read, synchronous write).

Function
REQ-015 The FSM SHALL have the states IDLE, READ, WRITE and FIN.
REQ-016 In IDLE, DMA_START=1 SHALL latch SRC, DST and LEN into internal registers; LEN=0 SHALL go to FIN, otherwise the FSM SHALL go to READ.
REQ-017 DMA_START SHALL be ignored in READ, WRITE and FIN.
REQ-018 In READ and WRITE, the DMA SHALL be granted when CPU_REQ=0 or wait_cnt==MAX_WAIT; otherwise the CPU SHALL be granted.
REQ-019 In IDLE and FIN, the CPU SHALL always be granted.
REQ-020 On a CPU grant, the block SHALL drive MEM_ADDRESS=CPU_ADDRESS, MEM_DATA_IN=CPU_DATA_IN and MEM_WRITE=CPU_REQ&CPU_WRITE, with CPU_STALL=0.
REQ-021 On a DMA grant in READ, the block SHALL drive MEM_ADDRESS=src and MEM_WRITE=0, capture MEM_DATA_OUT into buf at the clock edge, and go to WRITE.
REQ-022 On a DMA grant in WRITE, the block SHALL drive MEM_ADDRESS=dst, MEM_DATA_IN=buf and MEM_WRITE=1; at the edge it SHALL set src+=1, dst+=1 (mod 256, wrapping FF->00) and cnt-=1, then go to FIN if cnt becomes 0, otherwise to READ.
REQ-023 When the DMA is not granted in READ or WRITE, the state, src, dst, cnt and buf SHALL hold.
REQ-024 CPU_STALL SHALL be 1 only when CPU_REQ=1 and the DMA is granted (combinational).
REQ-025 wait_cnt (0..MAX_WAIT) SHALL increment when the FSM is in READ or WRITE, CPU_REQ=1 and the DMA is not granted.
REQ-026 wait_cnt SHALL clear to 0 on any DMA grant and in IDLE and FIN.
REQ-027 FIN SHALL last exactly one cycle with DONE=1 and then go to IDLE.
REQ-028 BUSY SHALL be 1 in READ and WRITE, and 0 in IDLE and FIN.
REQ-029 Every DMA byte SHALL take at least 2 granted cycles; a transfer of LEN bytes with no CPU traffic SHALL take 2*LEN cycles from READ entry, followed by 1 FIN cycle.
REQ-030 Addresses F0..FF SHALL be treated like RAM by this block; the memory alone decides the effect of an access there.
REQ-031 Overlapping source and destination ranges SHALL be copied in ascending address order, with no correction for the overlap.

Reset
REQ-032 On RESET=1, the block SHALL go to IDLE immediately and clear src, dst, cnt, buf and wait_cnt to 0.
REQ-033 While in reset, BUSY=0, DONE=0, MEM_WRITE=0 and CPU_STALL=0.
REQ-034 RESET asserted mid-transfer SHALL abort the transfer with no DONE pulse; the remaining bytes SHALL not be written.

Verification
REQ-035 Copy with no CPU traffic: RAM[10..12]=AA,BB,CC, then START SRC=10 DST=40 LEN=3, CPU_REQ=0 -> RAM[40..42]=AA,BB,CC, BUSY high for 6 cycles, DONE pulse in cycle 7.
REQ-036 Zero length: START LEN=0 -> DONE=1 in the next cycle, BUSY never 1, MEM_WRITE never 1.
REQ-037 Starvation, MAX_WAIT=4: CPU_REQ=1 continuously during a LEN=1 copy -> DMA read granted in the 5th cycle with CPU_STALL=1 that cycle only, write granted 5 cycles later, DONE follows.
REQ-038 Wrap-around: SRC=FE DST=20 LEN=3 -> reads from FE, FF, 00 and writes 20,21,22; output port F0 written when DST=F0 LEN=1.
REQ-039 Reset mid-transfer: RESET asserted after the second write of a LEN=5 copy -> only 2 bytes changed, BUSY=0 and DONE=0 immediately, and a subsequent START works normally.
REQ-040 START while busy: a second DMA_START during a LEN=4 copy with different SRC -> ignored, exactly 4 bytes copied from the original SRC, one DONE pulse.

Source files
------------

// File: rtl/dma_arbiter.sv
// Single-channel memory-to-memory DMA sharing one RAM port with the CPU.
// The CPU normally wins the port; the DMA wins when the CPU is idle or has starved it MAX_WAIT cycles.
//
//   state | meaning
//   IDLE  | no transfer; CPU owns the memory port; DMA_START latches a new job
//   READ  | DMA wants to read src into data_buf
//   WRITE | DMA wants to write data_buf to dst, then advance src/dst/cnt
//   FIN   | one-cycle DONE pulse, then back to IDLE
module dma_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CPU_REQ,
    input  logic       CPU_WRITE,
    input  logic [7:0] CPU_ADDRESS,
    input  logic [7:0] CPU_DATA_IN,
    output logic [7:0] CPU_DATA_OUT,
    output logic       CPU_STALL,
    input  logic       DMA_START,
    input  logic [7:0] DMA_SRC,
    input  logic [7:0] DMA_DST,
    input  logic [7:0] DMA_LEN,
    output logic       BUSY,
    output logic       DONE,
    output logic       MEM_WRITE,
    output logic [7:0] MEM_ADDRESS,
    output logic [7:0] MEM_DATA_IN,
    input  logic [7:0] MEM_DATA_OUT
);

    localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t        state;
    logic [7:0]    src;
    logic [7:0]    dst;
    logic [7:0]    cnt;
    logic [7:0]    data_buf;
    logic [WW-1:0] wait_cnt;
    logic          dma_active;
    logic          dma_grant;

    assign CPU_DATA_OUT = MEM_DATA_OUT;

    always_comb begin
        dma_active = (state == READ) || (state == WRITE);
        dma_grant  = dma_active && (!CPU_REQ || (wait_cnt == WAIT_MAX));
        CPU_STALL  = CPU_REQ && dma_grant;
        if (dma_grant) begin
            MEM_ADDRESS = (state == READ) ? src : dst;
            MEM_DATA_IN = data_buf;
            MEM_WRITE   = (state == WRITE);
        end else begin
            MEM_ADDRESS = CPU_ADDRESS;
            MEM_DATA_IN = CPU_DATA_IN;
            // the CPU still owns the port during reset, but no write may reach memory
            MEM_WRITE   = CPU_REQ && CPU_WRITE && !RESET;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            src      <= '0;
            dst      <= '0;
            cnt      <= '0;
            data_buf <= '0;
            wait_cnt <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (DMA_START) begin
                        src <= DMA_SRC;
                        dst <= DMA_DST;
                        cnt <= DMA_LEN;
                        if (DMA_LEN == 8'd0) begin
                            state <= FIN;
                            DONE  <= 1'b1;
                        end else begin
                            state <= READ;
                            BUSY  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (dma_grant) begin
                        data_buf <= MEM_DATA_OUT;
                        wait_cnt <= '0;
                        state    <= WRITE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                WRITE: begin
                    if (dma_grant) begin
                        src      <= src + 8'd1;
                        dst      <= dst + 8'd1;
                        cnt      <= cnt - 8'd1;
                        wait_cnt <= '0;
                        if (cnt == 8'd1) begin
                            state <= FIN;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                        end else begin
                            state <= READ;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                FIN: begin
                    wait_cnt <= '0;
                    DONE     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_arbiter.sv
// Bench for dma_arbiter: a RAM model on the memory port and an operation-queue model of the DMA.
// Directed copy scenarios pin the model with literal values; a random phase exercises arbitration.
module tb_dma_arbiter;

    localparam int MAX_WAIT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_req, cpu_write, cpu_stall;
    logic [7:0] cpu_addr, cpu_din, cpu_dout;
    logic       dma_start;
    logic [7:0] dma_src, dma_dst, dma_len;
    logic       busy, done;
    logic       mem_we;
    logic [7:0] mem_addr, mem_din, mem_dout;

    logic [7:0] ram [256];
    logic       ram_init;

    dma_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .CLK(clk), .RESET(rst),
        .CPU_REQ(cpu_req), .CPU_WRITE(cpu_write), .CPU_ADDRESS(cpu_addr),
        .CPU_DATA_IN(cpu_din), .CPU_DATA_OUT(cpu_dout), .CPU_STALL(cpu_stall),
        .DMA_START(dma_start), .DMA_SRC(dma_src), .DMA_DST(dma_dst), .DMA_LEN(dma_len),
        .BUSY(busy), .DONE(done),
        .MEM_WRITE(mem_we), .MEM_ADDRESS(mem_addr), .MEM_DATA_IN(mem_din),
        .MEM_DATA_OUT(mem_dout)
    );

    always #5 clk = ~clk;

    assign mem_dout = ram[mem_addr];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i * 7 + 3);
        end else if (mem_we) begin
            ram[mem_addr] <= mem_din;
        end
    end

    // Model: a pending transfer is a queue of memory operations (read src+i, write dst+i, ...).
    typedef struct {
        bit         wr;
        logic [7:0] addr;
    } op_t;

    op_t        ops[$];
    int         starve;
    bit         m_fin;
    logic [7:0] m_byte;
    logic [7:0] ref_mem [256];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    logic s_busy, s_done, s_stall, s_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input bit req, input bit wr, input logic [7:0] a, input logic [7:0] d,
                        input bit st, input logic [7:0] s, input logic [7:0] t, input logic [7:0] l);
        bit         act, grant, ewe, fin_next;
        logic [7:0] eaddr, edin;
        @(negedge clk);
        cpu_req = req; cpu_write = wr; cpu_addr = a; cpu_din = d;
        dma_start = st; dma_src = s; dma_dst = t; dma_len = l;
        #1;
        act   = ops.size() > 0;
        grant = act && (!req || starve == MAX_WAIT);
        if (grant) begin
            eaddr = ops[0].addr; ewe = ops[0].wr; edin = m_byte;
        end else begin
            eaddr = a; ewe = req & wr; edin = d;
        end
        chk("BUSY", 32'(busy), 32'(act));
        chk("DONE", 32'(done), 32'(m_fin));
        chk("CPU_STALL", 32'(cpu_stall), 32'(grant & req));
        chk("MEM_WRITE", 32'(mem_we), 32'(ewe));
        chk("MEM_ADDRESS", 32'(mem_addr), 32'(eaddr));
        if (!grant || ewe) chk("MEM_DATA_IN", 32'(mem_din), 32'(edin));
        chk("CPU_DATA_OUT", 32'(cpu_dout), 32'(ref_mem[eaddr]));
        s_busy = busy; s_done = done; s_stall = cpu_stall; s_we = mem_we;
        @(posedge clk);
        fin_next = 1'b0;
        if (grant) begin
            if (ewe) ref_mem[eaddr] = m_byte;
            else     m_byte = ref_mem[eaddr];
            void'(ops.pop_front());
            starve = 0;
            if (ops.size() == 0) fin_next = 1'b1;
        end else begin
            if (ewe) ref_mem[eaddr] = d;
            if (act && req) starve++;
            else            starve = 0;
        end
        if (st && !act && !m_fin) begin
            if (l == 8'd0) fin_next = 1'b1;
            else for (int i = 0; i < int'(l); i++) begin
                ops.push_back('{1'b0, 8'(int'(s) + i)});
                ops.push_back('{1'b1, 8'(int'(t) + i)});
            end
        end
        m_fin = fin_next;
        cyc++;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'($urandom), 8'($urandom), 1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
        step(1'b1, 1'b1, a, d, 1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic start(input logic [7:0] s, input logic [7:0] t, input logic [7:0] l);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, s, t, l);
    endtask

    task automatic cmp_mem(input string name);
        int bad = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) bad++;
        chk(name, 32'(bad), 32'd0);
    endtask

    task automatic reset_now();
        @(negedge clk);
        dma_start = 1'b0;
        cpu_req = 1'b1; cpu_write = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_BUSY", 32'(busy), 32'd0);
        chk("rst_DONE", 32'(done), 32'd0);
        chk("rst_MEM_WRITE", 32'(mem_we), 32'd0);
        chk("rst_CPU_STALL", 32'(cpu_stall), 32'd0);
        ops.delete(); starve = 0; m_fin = 1'b0; m_byte = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0; cpu_write = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        int bc, dc, wc, sc, st1, st2;
        rst = 1'b1; ram_init = 1'b1;
        cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = 8'h00; cpu_din = 8'h00;
        dma_start = 1'b0; dma_src = 8'h00; dma_dst = 8'h00; dma_len = 8'h00;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);
        starve = 0; m_fin = 1'b0; m_byte = 8'h00;
        @(posedge clk);
        #1 ram_init = 1'b0;
        reset_now();

        // plain copy, no CPU traffic
        cpu_wr(8'h10, 8'hAA); cpu_wr(8'h11, 8'hBB); cpu_wr(8'h12, 8'hCC);
        start(8'h10, 8'h40, 8'd3);
        bc = 0; dc = -1;
        for (int k = 1; k <= 8; k++) begin
            idle();
            if (s_busy) bc++;
            if (s_done && dc < 0) dc = k;
        end
        chk("copy_busy_cycles", 32'(bc), 32'd6);
        chk("copy_done_cycle", 32'(dc), 32'd7);
        chk("copy_ram40", 32'(ram[8'h40]), 32'hAA);
        chk("copy_ram41", 32'(ram[8'h41]), 32'hBB);
        chk("copy_ram42", 32'(ram[8'h42]), 32'hCC);
        cmp_mem("copy_mem");

        // zero length
        bc = 0; dc = -1; wc = 0;
        start(8'h10, 8'h50, 8'd0);
        if (s_we) wc++;
        for (int k = 1; k <= 3; k++) begin
            idle();
            if (s_busy) bc++;
            if (s_we) wc++;
            if (s_done && dc < 0) dc = k;
        end
        chk("zero_done_cycle", 32'(dc), 32'd1);
        chk("zero_busy_cycles", 32'(bc), 32'd0);
        chk("zero_write_cycles", 32'(wc), 32'd0);

        // starvation with continuous CPU reads
        step(1'b1, 1'b0, 8'h33, 8'h00, 1'b1, 8'h10, 8'h48, 8'd1);
        sc = 0; st1 = -1; st2 = -1; dc = -1;
        for (int k = 1; k <= 12; k++) begin
            step(1'b1, 1'b0, 8'(k), 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
            if (s_stall) begin
                sc++;
                if (st1 < 0) st1 = k; else if (st2 < 0) st2 = k;
            end
            if (s_done && dc < 0) dc = k;
        end
        chk("starve_first_stall", 32'(st1), 32'd5);
        chk("starve_second_stall", 32'(st2), 32'd10);
        chk("starve_stall_count", 32'(sc), 32'd2);
        chk("starve_done_cycle", 32'(dc), 32'd11);
        chk("starve_ram48", 32'(ram[8'h48]), 32'hAA);

        // address wrap and the F0 output port
        cpu_wr(8'hFE, 8'h11); cpu_wr(8'hFF, 8'h22); cpu_wr(8'h00, 8'h33);
        start(8'hFE, 8'h20, 8'd3);
        repeat (8) idle();
        chk("wrap_ram20", 32'(ram[8'h20]), 32'h11);
        chk("wrap_ram21", 32'(ram[8'h21]), 32'h22);
        chk("wrap_ram22", 32'(ram[8'h22]), 32'h33);
        start(8'h00, 8'hF0, 8'd1);
        repeat (3) idle();
        chk("port_f0", 32'(ram[8'hF0]), 32'h33);
        cmp_mem("wrap_mem");

        // reset after the second write of a 5-byte copy
        for (int i = 0; i < 5; i++) cpu_wr(8'(8'h50 + i), 8'(8'h91 + i));
        for (int i = 0; i < 5; i++) cpu_wr(8'(8'h60 + i), 8'(8'hE0 + i));
        start(8'h50, 8'h60, 8'd5);
        repeat (4) idle();
        reset_now();
        chk("abort_ram60", 32'(ram[8'h60]), 32'h91);
        chk("abort_ram61", 32'(ram[8'h61]), 32'h92);
        chk("abort_ram62", 32'(ram[8'h62]), 32'hE2);
        chk("abort_ram64", 32'(ram[8'h64]), 32'hE4);
        cmp_mem("abort_mem");
        start(8'h50, 8'h62, 8'd2);
        dc = 0;
        repeat (6) begin idle(); if (s_done) dc++; end
        chk("restart_done_count", 32'(dc), 32'd1);
        chk("restart_ram62", 32'(ram[8'h62]), 32'h91);
        chk("restart_ram63", 32'(ram[8'h63]), 32'h92);

        // second START while busy is ignored
        for (int i = 0; i < 4; i++) cpu_wr(8'(8'h30 + i), 8'(8'hC0 + i));
        for (int i = 0; i < 4; i++) cpu_wr(8'(8'h38 + i), 8'(8'hD0 + i));
        start(8'h30, 8'hA0, 8'd4);
        dc = 0;
        repeat (2) begin idle(); if (s_done) dc++; end
        start(8'h38, 8'hB0, 8'd4);
        if (s_done) dc++;
        repeat (12) begin idle(); if (s_done) dc++; end
        chk("busy_start_done_count", 32'(dc), 32'd1);
        chk("busy_start_ramA0", 32'(ram[8'hA0]), 32'hC0);
        chk("busy_start_ramA3", 32'(ram[8'hA3]), 32'hC3);
        chk("busy_start_ramB0", 32'(ram[8'hB0]), 32'(8'((8'hB0 * 7 + 3) & 8'hFF)));
        cmp_mem("busy_start_mem");

        // random CPU traffic and DMA jobs
        for (int k = 0; k < 600; k++) begin
            step(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 7) == 0), 8'($urandom), 8'($urandom),
                 8'($urandom_range(0, 5)));
        end
        repeat (40) idle();
        cmp_mem("random_mem");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
